// File: rtl/jb_fft_multi_cntr_if.sv
// Control/status bundle between the FFT control FSM and the multi-channel index counter.
// Latency: none, wires only.
// Backpressure: none; the master stalls counting through clk_en / enable.
// Optional macro JB_MULTI_CNTR_ERR_EN adds the sticky per-channel err status.
interface jb_fft_multi_cntr_if #(
  parameter int COUNT_WIDTH = 39,
  parameter int NUM_CH      = 4,
  parameter int STEP_WIDTH  = 16
);
  logic                          clk_en;
  logic [NUM_CH-1:0]             enable;
  logic [NUM_CH-1:0]             cascade;
  logic [NUM_CH-1:0]             mode;
  logic [NUM_CH*STEP_WIDTH-1:0]  step;
  logic [NUM_CH*COUNT_WIDTH-1:0] max_value;
  logic [NUM_CH-1:0]             load;
  logic [NUM_CH*COUNT_WIDTH-1:0] load_value;
  logic [NUM_CH*COUNT_WIDTH-1:0] cntr;
  logic [NUM_CH-1:0]             wrap;
  logic [NUM_CH-1:0]             sat;
`ifdef JB_MULTI_CNTR_ERR_EN
  logic [NUM_CH-1:0]             err;
`endif

  // Controller side: drives configuration/strobes, observes counter state.
  modport master (
    output clk_en, enable, cascade, mode, step, max_value, load, load_value,
`ifdef JB_MULTI_CNTR_ERR_EN
    input  err,
`endif
    input  cntr, wrap, sat
  );

  // Counter side.
  modport slave (
    input  clk_en, enable, cascade, mode, step, max_value, load, load_value,
`ifdef JB_MULTI_CNTR_ERR_EN
    output err,
`endif
    output cntr, wrap, sat
  );
endinterface

// File: rtl/jb_fft_multi_cntr.sv
// Multi-channel modulo/saturating index counter with carry cascade for nested FFT/PRACH loops.
// Latency: 1 clk from any input to cntr/wrap/sat.
// Backpressure: none; clk_en freezes cntr/sat, wrap drops to 0 one clk later.
// Optional macro JB_MULTI_CNTR_ERR_EN adds sticky err flags for out-of-range step/count.
module jb_fft_multi_cntr #(
  parameter int COUNT_WIDTH = 39,
  parameter int NUM_CH      = 4,
  parameter int STEP_WIDTH  = 16
) (
  input logic clk,
  input logic reset,
  jb_fft_multi_cntr_if.slave bus
);

  localparam int W1 = COUNT_WIDTH + 1;

  logic [NUM_CH*COUNT_WIDTH-1:0] cntr_q, cntr_d;
  logic [NUM_CH-1:0]             wrap_q, wrap_d;
  logic [NUM_CH-1:0]             sat_q, sat_d;
`ifdef JB_MULTI_CNTR_ERR_EN
  logic [NUM_CH-1:0]             err_q, err_d;
`endif

  // Per-channel next state; carry ripples from channel 0 upward so a full chain moves in one clk.
  always_comb begin
    logic                   chain;
    logic                   ld;
    logic                   adv;
    logic                   ev;
    logic                   hit;
    logic [W1-1:0]          cur;
    logic [W1-1:0]          mx;
    logic [W1-1:0]          mx1;
    logic [W1-1:0]          stp;
    logic [W1-1:0]          sum;
    logic [W1-1:0]          diff;
    logic [COUNT_WIDTH-1:0] nxt;

    cntr_d = cntr_q;
    wrap_d = '0;
    sat_d  = sat_q;
`ifdef JB_MULTI_CNTR_ERR_EN
    err_d  = err_q;
`endif
    // Channel 0 sees a permanent carry-in, which makes its cascade bit a don't-care.
    chain = 1'b1;
    ld    = 1'b0;
    adv   = 1'b0;
    ev    = 1'b0;
    hit   = 1'b0;
    cur   = '0;
    mx    = '0;
    mx1   = '0;
    stp   = '0;
    sum   = '0;
    diff  = '0;
    nxt   = '0;

    for (int i = 0; i < NUM_CH; i++) begin
      cur  = {1'b0, cntr_q[i*COUNT_WIDTH +: COUNT_WIDTH]};
      mx   = {1'b0, bus.max_value[i*COUNT_WIDTH +: COUNT_WIDTH]};
      mx1  = mx + W1'(1);
      stp  = W1'(bus.step[i*STEP_WIDTH +: STEP_WIDTH]);
      sum  = cur + stp;
      diff = sum - mx1;

      ld  = bus.clk_en & bus.load[i];
      adv = bus.clk_en & bus.enable[i] & ~bus.load[i] & (~bus.cascade[i] | chain);

      ev  = 1'b0;
      hit = 1'b0;
      nxt = sum[COUNT_WIDTH-1:0];
      if (!bus.mode[i]) begin
        // Wrap: an out-of-range count restarts at 0; otherwise keep the residue past max.
        if (cur > mx) begin
          nxt = '0;
          ev  = 1'b1;
        end else if (sum > mx) begin
          nxt = diff[COUNT_WIDTH-1:0];
          ev  = 1'b1;
        end
      end else begin
        // Saturate: clamp at max; only the 0->1 transition of sat counts as a carry.
        hit = (sum >= mx) | (cur > mx);
        if (hit) begin
          nxt = mx[COUNT_WIDTH-1:0];
          ev  = ~sat_q[i];
        end
      end

      if (ld) begin
        cntr_d[i*COUNT_WIDTH +: COUNT_WIDTH] = bus.load_value[i*COUNT_WIDTH +: COUNT_WIDTH];
        sat_d[i] = 1'b0;
      end else if (adv) begin
        cntr_d[i*COUNT_WIDTH +: COUNT_WIDTH] = nxt;
        if (hit) begin
          sat_d[i] = 1'b1;
        end
      end

`ifdef JB_MULTI_CNTR_ERR_EN
      if (ld) begin
        err_d[i] = 1'b0;
      end else if (adv && ((stp > mx1) || (cur > mx))) begin
        err_d[i] = 1'b1;
      end
`endif

      wrap_d[i] = adv & ev;
      chain     = adv & ev;
    end
  end

  // State registers; clk_en gating lives in the next-state terms so wrap always clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cntr_q <= '0;
      wrap_q <= '0;
      sat_q  <= '0;
    end else begin
      cntr_q <= cntr_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

`ifdef JB_MULTI_CNTR_ERR_EN
  // Sticky range-error flags, cleared by load or reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`endif

  assign bus.cntr = cntr_q;
  assign bus.wrap = wrap_q;
  assign bus.sat  = sat_q;

endmodule

// File: tb/tb_jb_fft_multi_cntr.sv
// Directed self-checking bench for jb_fft_multi_cntr.
// Inputs change 1 ns after the rising edge; outputs are sampled at that same point.
module tb_jb_fft_multi_cntr;
    localparam int CW = 39;
    localparam int NC = 4;
    localparam int SW = 16;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    logic done;

    jb_fft_multi_cntr_if #(.COUNT_WIDTH(CW), .NUM_CH(NC), .STEP_WIDTH(SW)) bus ();

    jb_fft_multi_cntr #(.COUNT_WIDTH(CW), .NUM_CH(NC), .STEP_WIDTH(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int e1_c [8]  = '{1, 2, 3, 4, 5, 0, 1, 2};
    int e1_w [8]  = '{0, 0, 0, 0, 0, 1, 0, 0};
    int e2_c [6]  = '{4, 8, 2, 6, 0, 4};
    int e2_w [6]  = '{0, 0, 1, 0, 1, 0};
    int e3_c0[12] = '{1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2, 0};
    int e3_c1[12] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
    int e3_w0[12] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    int e3_w1[12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    int e4_c [5]  = '{3, 6, 9, 10, 10};
    int e4_s [5]  = '{0, 0, 0, 1, 1};
    int e4_w [5]  = '{0, 0, 0, 1, 0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CW-1:0] c(input int ch);
        return bus.cntr[ch*CW +: CW];
    endfunction

    task automatic set_ch(input int ch, input logic [CW-1:0] mx, input logic [SW-1:0] st);
        bus.max_value[ch*CW +: CW] = mx;
        bus.step[ch*SW +: SW]      = st;
    endtask

    task automatic set_lv(input int ch, input logic [CW-1:0] v);
        bus.load_value[ch*CW +: CW] = v;
    endtask

    initial begin
        #100000;
        if (!done) begin
            n_err++;
            $error("FAIL timeout: bench did not complete");
            $finish;
        end
    end

    initial begin
        done  = 1'b0;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.clk_en     = 1'b1;
        bus.enable     = '0;
        bus.cascade    = '0;
        bus.mode       = '0;
        bus.step       = '0;
        bus.max_value  = '0;
        bus.load       = '0;
        bus.load_value = '0;

        tick();
        tick();
        for (int ch = 0; ch < NC; ch++) chk("rst_cntr", c(ch), 0);
        chk("rst_wrap", bus.wrap, 0);
        chk("rst_sat", bus.sat, 0);

        set_ch(0, 5, 1);
        bus.enable = 4'b0001;
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t1_cntr", c(0), e1_c[k]);
            chk("t1_wrap", bus.wrap[0], e1_w[k]);
        end

        bus.enable = '0;
        bus.load   = 4'b0001;
        set_lv(0, 0);
        tick();
        chk("t2_load", c(0), 0);
        bus.load = '0;
        set_ch(0, 9, 4);
        bus.enable = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t2_cntr", c(0), e2_c[k]);
            chk("t2_wrap", bus.wrap[0], e2_w[k]);
        end

        bus.enable  = '0;
        set_ch(0, 2, 1);
        set_ch(1, 1, 1);
        bus.cascade = 4'b0010;
        set_lv(1, 0);
        bus.load    = 4'b0011;
        tick();
        chk("t3_load0", c(0), 0);
        chk("t3_load1", c(1), 0);
        bus.load   = '0;
        bus.enable = 4'b0011;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("t3_cntr0", c(0), e3_c0[k]);
            chk("t3_cntr1", c(1), e3_c1[k]);
            chk("t3_wrap0", bus.wrap[0], e3_w0[k]);
            chk("t3_wrap1", bus.wrap[1], e3_w1[k]);
        end
        bus.enable  = '0;
        bus.cascade = '0;

        set_ch(2, 10, 3);
        bus.mode   = 4'b0100;
        bus.enable = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_cntr", c(2), e4_c[k]);
            chk("t4_sat", bus.sat[2], e4_s[k]);
            chk("t4_wrap", bus.wrap[2], e4_w[k]);
        end
        set_lv(2, 0);
        bus.load = 4'b0100;
        tick();
        chk("t4_ld_cntr", c(2), 0);
        chk("t4_ld_sat", bus.sat[2], 0);
        chk("t4_ld_wrap", bus.wrap[2], 0);
        bus.load   = '0;
        bus.enable = '0;
        bus.mode   = '0;

        set_ch(3, 100, 1);
        bus.enable = 4'b1000;
        set_lv(3, 7);
        bus.load   = 4'b1000;
        tick();
        chk("t5_load", c(3), 7);
        chk("t5_load_wrap", bus.wrap, 0);
        bus.load = '0;
        bus.clk_en = 1'b1; tick(); chk("t5_en1a", c(3), 8);
        bus.clk_en = 1'b0; tick(); chk("t5_en0a", c(3), 8);
        bus.clk_en = 1'b1; tick(); chk("t5_en1b", c(3), 9);
        bus.clk_en = 1'b0; tick(); chk("t5_en0b", c(3), 9);
        chk("t5_en0_wrap", bus.wrap, 0);
        bus.clk_en = 1'b1;

        set_lv(3, 8);
        bus.load = 4'b1000;
        tick();
        chk("t6_load", c(3), 8);
        bus.load = '0;
        set_ch(3, 3, 1);
        tick();
        chk("t6_cntr", c(3), 0);
        chk("t6_wrap", bus.wrap[3], 1);
`ifdef JB_MULTI_CNTR_ERR_EN
        chk("t6_err_set", bus.err[3], 1);
`endif
        tick();
        chk("t6_next", c(3), 1);
        chk("t6_next_wrap", bus.wrap[3], 0);
`ifdef JB_MULTI_CNTR_ERR_EN
        chk("t6_err_hold", bus.err[3], 1);
`endif

        set_ch(3, 3, 0);
        tick();
        tick();
        chk("t7_hold", c(3), 1);
        chk("t7_hold_wrap", bus.wrap[3], 0);
        set_lv(3, 2);
        bus.load = 4'b1000;
        tick();
        chk("t7_load", c(3), 2);
`ifdef JB_MULTI_CNTR_ERR_EN
        chk("t7_err_clr", bus.err[3], 0);
`endif
        bus.load = '0;
        set_ch(3, 1, 0);
        tick();
        chk("t7_s0_cntr", c(3), 0);
        chk("t7_s0_wrap", bus.wrap[3], 1);
        bus.enable = '0;

        bus.enable = 4'b0001;
        tick();
        tick();
        chk("t8_pre", c(0), 2);
        reset = 1'b1;
        #2;
        chk("t8_async_c0", c(0), 0);
        chk("t8_async_c3", c(3), 0);
        chk("t8_async_wrap", bus.wrap, 0);
        tick();
        reset = 1'b0;

        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/jb_fft_multi_cntr.md
Name: jb_fft_multi_cntr

Overview:
Multi-channel, parametrised index counter for FFT/PRACH address and loop generation. Each channel counts modulo (max_value+1) with a programmable step. Each channel runs in wrap or saturate mode. A channel can be cascaded onto the carry of the channel below it, so nested loops (symbol / bin / sample) come from a single block. It sits between the FFT control FSM and the buffer address generators.

Parameters:
COUNT_WIDTH, 39, width of each channel counter, max_value and load_value
NUM_CH, 4, number of counter channels (1..8)
STEP_WIDTH, 16, width of each channel's step; STEP_WIDTH <= COUNT_WIDTH

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous active-high reset
clk_en  in  1  global clock enable; gates every counter and load update
enable  in  NUM_CH  per-channel count enable
cascade  in  NUM_CH  per-channel: 1 = advance only on carry of channel i-1; bit 0 ignored
mode  in  NUM_CH  per-channel: 0 = wrap, 1 = saturate
step  in  NUM_CH*STEP_WIDTH  per-channel increment, channel i at [i*STEP_WIDTH +: STEP_WIDTH]
max_value  in  NUM_CH*COUNT_WIDTH  per-channel terminal value, inclusive
load  in  NUM_CH  per-channel synchronous load strobe
load_value  in  NUM_CH*COUNT_WIDTH  per-channel load value
cntr  out  NUM_CH*COUNT_WIDTH  registered counter values
wrap  out  NUM_CH  one-clk pulse, registered, coincident with the wrapped cntr value
sat  out  NUM_CH  registered level: saturate-mode channel has reached max_value

Behaviour:
- Reset (async, active-high): all cntr = 0, wrap = 0, sat = 0. The block resumes on the first clk edge after reset deasserts. Reset mid-count discards all state.
- Per channel i, all evaluated combinationally within one cycle:
  - ld_i = clk_en & load[i]
  - adv_i = clk_en & enable[i] & !load[i] & (i==0 | !cascade[i] | carry_{i-1})
  - sum_i = cntr_i + step_i, computed in COUNT_WIDTH+1 bits (no overflow loss)
- Priority: load > advance > hold. Load ignores enable and cascade. A loading channel produces carry_i = 0.
- Load: cntr_i <= load_value_i and sat_i <= 0. Values above max_value load unchanged.
- Wrap mode (mode=0), when adv_i:
  - cntr_i > max_i: next = 0, wrap event.
  - sum_i > max_i: next = sum_i - (max_i+1), wrap event. Residue is preserved.
  - otherwise: next = sum_i, no event.
- Saturate mode (mode=1), when adv_i:
  - sum_i >= max_i or cntr_i > max_i: next = max_i.
  - sat_i <= 1. Carry event only on the cycle sat_i goes 0->1.
  - Further advances hold max_i with no carry.
- carry_i = adv_i & event_i. carry ripples combinationally from channel 0 upward in the same cycle: a full cascade chain advances in one clk.
- wrap[i] <= carry_i on every clk edge, not gated by clk_en. Pulse width is exactly one clk. In saturate mode wrap also pulses on the saturating transition.
- step = 0: counter holds. It still wraps to 0 if cntr > max.
- Usage rule: step <= max_value+1. Outside this rule the result is sum-(max+1) truncated to COUNT_WIDTH, with no further correction.
- max_value and mode may change at any time and take effect on the next advance. Switching mode does not clear sat; only load or reset clears it.
- clk_en = 0: cntr and sat hold; wrap returns to 0 after one clk.
- Latency: input to cntr/wrap/sat is 1 clk.

Optional Feature:
JB_MULTI_CNTR_ERR_EN
- Defined: adds output port err (NUM_CH, sticky). err[i] sets on any advance with step_i > max_i+1 or cntr_i > max_i. It clears only on reset or load[i] & clk_en.
- Undefined: port and logic absent. Counting behaviour is identical in both builds.

Test Plan:
- Ch0 wrap, max=5, step=1, enable=1 for 8 clk from reset -> cntr 1,2,3,4,5,0,1,2; wrap high only with the first 0.
- Ch0 wrap, max=9, step=4, start 0 -> cntr 4,8,2,6,0,4; wrap with 2 and with 0.
- Cascade: ch0 max=2, ch1 max=1 cascade=1, both enabled, 12 clk -> (ch1,ch0) steps through (0,1)(0,2)(1,0)(1,1)(1,2)(0,0)..., ch1 wrap coincident with ch0 wrap when ch1 returns to 0.
- Saturate: ch2 mode=1, max=10, step=3 -> cntr 3,6,9,10,10; sat=1 from the first 10; wrap one pulse only; load 0 -> cntr=0, sat=0.
- Load vs advance vs clk_en: load=1, load_value=7 with enable=1 -> cntr=7, no wrap. clk_en toggling 1010 -> advance only on the clk_en=1 edges. Reset asserted mid-count -> cntr=0 immediately, without waiting for a clk edge.
- max lowered below cntr (cntr=8, max set to 3) -> next advance gives 0 with a wrap pulse. With JB_MULTI_CNTR_ERR_EN defined, err[i]=1 and stays set until load.
